// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - request/response handshake bundle between the memory stage and the data-memory responder
interface dmem_responder_if #(
   parameter int word_width = 32
);
   logic                    req_valid;
   logic                    req_ready;
   logic                    req_write;
   logic [word_width-1:0]   req_addr;
   logic [word_width-1:0]   req_wdata;
   logic [word_width/8-1:0] req_wstrb;
   logic                    rsp_valid;
   logic                    rsp_ready;
   logic [word_width-1:0]   rsp_rdata;
   logic                    rsp_err;
   logic                    busy;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
   );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-outstanding data-memory responder with fixed access latency
module dmem_responder #(
   parameter int word_width  = 32,
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input logic            i_clk,
   input logic            i_rst,
   dmem_responder_if.slave bus
);
   localparam int         IDX_W  = $clog2(DEPTH_WORDS);
   localparam int         STRB_W = word_width / 8;
   localparam logic [3:0] LAT_M1 = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t                r_state;
   logic [3:0]            r_cnt;
   logic                  r_write;
   logic [IDX_W-1:0]      r_idx;
   logic [word_width-1:0] r_wdata;
   logic [STRB_W-1:0]     r_wstrb;
   logic                  r_rsp_valid;
   logic                  r_rsp_err;
   logic [word_width-1:0] r_rsp_rdata;
   logic                  r_busy;
   logic [word_width-1:0] r_mem [DEPTH_WORDS];

   logic                  w_fire;
   logic                  w_req_err;
   logic                  w_imm;
   logic                  w_wait_done;
   logic                  w_acc_write;
   logic [IDX_W-1:0]      w_idx;
   logic [word_width-1:0] w_acc_wdata;
   logic [STRB_W-1:0]     w_acc_wstrb;
   logic                  w_mem_we;
   logic [word_width-1:0] w_rd_word;

   assign w_fire      = (r_state == S_IDLE) && bus.req_valid;
   assign w_req_err   = (bus.req_addr[1:0] != 2'b00) || (|bus.req_addr[word_width-1:IDX_W+2]);
   assign w_imm       = w_fire && !w_req_err && (LATENCY == 0);
   assign w_wait_done = (r_state == S_WAIT) && (r_cnt == 4'd0);

   // Zero-latency accesses use the live request; otherwise the captured copy.
   assign w_acc_write = w_imm ? bus.req_write : r_write;
   assign w_idx       = w_imm ? bus.req_addr[IDX_W+1:2] : r_idx;
   assign w_acc_wdata = w_imm ? bus.req_wdata : r_wdata;
   assign w_acc_wstrb = w_imm ? bus.req_wstrb : r_wstrb;
   assign w_mem_we    = !i_rst && w_acc_write && (w_imm || w_wait_done);
   assign w_rd_word   = r_mem[w_idx];

   assign bus.req_ready = (r_state == S_IDLE);
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_rdata = r_rsp_rdata;
   assign bus.rsp_err   = r_rsp_err;
   assign bus.busy      = r_busy;

   always_ff @(posedge i_clk) begin
      if (w_mem_we) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (w_acc_wstrb[b]) begin
               r_mem[w_idx][8*b +: 8] <= w_acc_wdata[8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= 4'd0;
         r_write     <= 1'b0;
         r_idx       <= '0;
         r_wdata     <= '0;
         r_wstrb     <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_rdata <= '0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.req_valid) begin
                  r_write <= bus.req_write;
                  r_idx   <= bus.req_addr[IDX_W+1:2];
                  r_wdata <= bus.req_wdata;
                  r_wstrb <= bus.req_wstrb;
                  r_busy  <= 1'b1;
                  if (w_req_err) begin
                     r_state     <= S_RESP;
                     r_rsp_valid <= 1'b1;
                     r_rsp_err   <= 1'b1;
                     r_rsp_rdata <= '0;
                  end else if (LATENCY == 0) begin
                     r_state     <= S_RESP;
                     r_rsp_valid <= 1'b1;
                     r_rsp_err   <= 1'b0;
                     r_rsp_rdata <= bus.req_write ? '0 : w_rd_word;
                  end else begin
                     r_state <= S_WAIT;
                     r_cnt   <= LAT_M1;
                  end
               end
            end
            S_WAIT: begin
               if (r_cnt == 4'd0) begin
                  r_state     <= S_RESP;
                  r_rsp_valid <= 1'b1;
                  r_rsp_err   <= 1'b0;
                  r_rsp_rdata <= r_write ? '0 : w_rd_word;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            S_RESP: begin
               if (bus.rsp_ready) begin
                  r_state     <= S_IDLE;
                  r_rsp_valid <= 1'b0;
                  r_rsp_err   <= 1'b0;
                  r_rsp_rdata <= '0;
                  r_busy      <= 1'b0;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed bench driving LATENCY=2, 3 and 0 responders with one shared request stream
module tb_dmem_responder;
   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_wstrb;
   logic        rsp_ready;

   int n_tests = 0;
   int n_fail  = 0;

   dmem_responder_if if2 ();
   dmem_responder_if if3 ();
   dmem_responder_if if0 ();

   assign if2.req_valid = req_valid;
   assign if2.req_write = req_write;
   assign if2.req_addr  = req_addr;
   assign if2.req_wdata = req_wdata;
   assign if2.req_wstrb = req_wstrb;
   assign if2.rsp_ready = rsp_ready;
   assign if3.req_valid = req_valid;
   assign if3.req_write = req_write;
   assign if3.req_addr  = req_addr;
   assign if3.req_wdata = req_wdata;
   assign if3.req_wstrb = req_wstrb;
   assign if3.rsp_ready = rsp_ready;
   assign if0.req_valid = req_valid;
   assign if0.req_write = req_write;
   assign if0.req_addr  = req_addr;
   assign if0.req_wdata = req_wdata;
   assign if0.req_wstrb = req_wstrb;
   assign if0.rsp_ready = rsp_ready;

   dmem_responder #(.LATENCY(2)) u_dut2 (.i_clk(clk), .i_rst(rst), .bus(if2.slave));
   dmem_responder #(.LATENCY(3)) u_dut3 (.i_clk(clk), .i_rst(rst), .bus(if3.slave));
   dmem_responder #(.LATENCY(0)) u_dut0 (.i_clk(clk), .i_rst(rst), .bus(if0.slave));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Returns at the falling edge right after the accepting edge A.
   task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb);
      @(negedge clk);
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = addr;
      req_wdata = wdata;
      req_wstrb = strb;
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic settle();
      repeat (4) @(negedge clk);
   endtask

   // Read on all three; checks each responder in its own response cycle.
   task automatic read_all(input string tag, input logic [31:0] addr, input logic [31:0] e2, input logic [31:0] e3, input logic [31:0] e0);
      issue(1'b0, addr, 32'h0, 4'h0);
      check({tag, "_l0"}, if0.rsp_rdata, e0);
      repeat (2) @(negedge clk);
      check({tag, "_l2"}, if2.rsp_rdata, e2);
      @(negedge clk);
      check({tag, "_l3"}, if3.rsp_rdata, e3);
      settle();
   endtask

   initial begin
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = 32'h0;
      req_wdata = 32'h0;
      req_wstrb = 4'h0;
      rsp_ready = 1'b1;
      rst       = 1'b0;
      #3 rst = 1'b1;
      #1;
      check("rst_req_ready", {31'h0, if2.req_ready}, 32'h1);
      check("rst_rsp_valid", {31'h0, if2.rsp_valid}, 32'h0);
      check("rst_busy",      {31'h0, if2.busy}, 32'h0);
      check("rst_rdata",     if2.rsp_rdata, 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
      check("wr_busy",     {31'h0, if2.busy}, 32'h1);
      check("wr_ready0",   {31'h0, if2.req_ready}, 32'h0);
      check("wr_l0_valid", {31'h0, if0.rsp_valid}, 32'h1);
      @(negedge clk);
      check("wr_valid_e1", {31'h0, if2.rsp_valid}, 32'h0);
      @(negedge clk);
      check("wr_valid_e2", {31'h0, if2.rsp_valid}, 32'h1);
      check("wr_err",      {31'h0, if2.rsp_err}, 32'h0);
      check("wr_rdata",    if2.rsp_rdata, 32'h0);
      settle();

      read_all("rd_full", 32'h10, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
      issue(1'b1, 32'h10, 32'h00AA0000, 4'b0100);
      settle();
      read_all("rd_lane2", 32'h10, 32'hDEAABEEF, 32'hDEAABEEF, 32'hDEAABEEF);
      issue(1'b1, 32'h10, 32'hFFFFFFFF, 4'h0);
      settle();
      read_all("rd_strb0", 32'h10, 32'hDEAABEEF, 32'hDEAABEEF, 32'hDEAABEEF);

      issue(1'b1, 32'h0, 32'hCAFEF00D, 4'hF);
      settle();
      issue(1'b0, 32'h13, 32'h0, 4'h0);
      check("mis_valid", {31'h0, if2.rsp_valid}, 32'h1);
      check("mis_err",   {31'h0, if2.rsp_err}, 32'h1);
      check("mis_rdata", if2.rsp_rdata, 32'h0);
      settle();
      issue(1'b1, 32'h1000, 32'h12345678, 4'hF);
      check("oob_valid",  {31'h0, if2.rsp_valid}, 32'h1);
      check("oob_err",    {31'h0, if2.rsp_err}, 32'h1);
      check("oob_l3_err", {31'h0, if3.rsp_err}, 32'h1);
      settle();
      read_all("rd_alias", 32'h0, 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D);

      rsp_ready = 1'b0;
      issue(1'b0, 32'h10, 32'h0, 4'h0);
      repeat (2) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         req_valid = 1'b1;
         req_write = 1'b1;
         req_addr  = 32'h10;
         req_wdata = 32'h0;
         req_wstrb = 4'hF;
         @(negedge clk);
         check("hold_valid", {31'h0, if2.rsp_valid}, 32'h1);
         check("hold_rdata", if2.rsp_rdata, 32'hDEAABEEF);
         check("hold_err",   {31'h0, if2.rsp_err}, 32'h0);
         check("hold_ready", {31'h0, if2.req_ready}, 32'h0);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      check("rel_valid", {31'h0, if2.rsp_valid}, 32'h0);
      check("rel_ready", {31'h0, if2.req_ready}, 32'h1);
      check("rel_busy",  {31'h0, if2.busy}, 32'h0);
      settle();
      read_all("rd_ignored", 32'h10, 32'hDEAABEEF, 32'hDEAABEEF, 32'hDEAABEEF);

      issue(1'b1, 32'h20, 32'h11111111, 4'hF);
      settle();
      issue(1'b1, 32'h20, 32'h00000055, 4'hF);
      @(negedge clk);
      check("pre_rst_l3_busy", {31'h0, if3.busy}, 32'h1);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_ready", {31'h0, if3.req_ready}, 32'h1);
      check("mid_rst_valid", {31'h0, if3.rsp_valid}, 32'h0);
      check("mid_rst_busy",  {31'h0, if3.busy}, 32'h0);
      check("mid_rst_rdata", if3.rsp_rdata, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      read_all("rd_after_rst", 32'h20, 32'h11111111, 32'h11111111, 32'h00000055);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the pipelined RV32 core; sits on the far side of the memory-stage request interface.
- Accepts one read or write request at a time over a valid/ready handshake, applies a fixed programmable access latency, and returns read data or an error over a second valid/ready handshake.
- Exports busy so the hazard unit can stall the pipeline while an access is outstanding.

Parameters:
word_width, 32, data and address width in bits
DEPTH_WORDS, 1024, number of word_width-bit words in the array (power of two)
LATENCY, 2, extra wait cycles between acceptance and response (legal range 0..15)

Ports:
clk  input  1  single clock, rising-edge
rst  input  1  asynchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  responder can accept a request
req_write  input  1  1 = write, 0 = read
req_addr  input  word_width  byte address
req_wdata  input  word_width  write data
req_wstrb  input  word_width/8  byte-lane write enables
rsp_valid  output  1  response present
rsp_ready  input  1  requester accepts response
rsp_rdata  output  word_width  read data (0 for writes and errors)
rsp_err  output  1  misaligned or out-of-range access
busy  output  1  high whenever state != IDLE

Behaviour:
- One clock (clk); rst is asynchronous and active-high.
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, wait counter=0. The array is not cleared.
- States: IDLE, WAIT, RESP. req_ready = (state==IDLE), combinational.
- IDLE: on req_valid at a rising edge (edge A), capture write, addr, wdata and wstrb.
  - err = (addr[1:0]!=0) | (addr >= DEPTH_WORDS*4).
  - If err: go to RESP at edge A with rsp_err=1, rsp_rdata=0, no array access, independent of LATENCY.
  - Else if LATENCY==0: perform the access at edge A and go to RESP.
  - Else: go to WAIT with counter=LATENCY-1.
- WAIT: decrement the counter each edge. At the edge where the counter is 0, perform the access and go to RESP. For a valid access, rsp_valid is first high in the cycle after edge A+LATENCY.
- Access:
  - Word index = addr[log2(DEPTH_WORDS)+1:2].
  - Write: byte lane i is updated iff wstrb[i]. rsp_rdata=0, rsp_err=0.
  - Read: rsp_rdata = array word (value before any same-edge write, though none can occur). rsp_err=0.
  - wstrb ignored on reads. A write with wstrb=0 completes normally and leaves the array unchanged.
- RESP: rsp_valid=1. rsp_rdata and rsp_err are held stable until rsp_ready is sampled high; on that edge go to IDLE.
  - rsp_valid and rsp_ready in the same cycle as a new req_valid: the request is not accepted until the following cycle, when req_ready=1. There is no back-to-back acceptance.
- req_valid while not in IDLE is ignored, with no capture.
- Reset mid-operation returns to IDLE immediately.
  - A write still in WAIT is dropped; the array is unchanged.
  - A write already committed (in RESP) persists.
- busy is a registered function of state only, with no combinational path from req_valid.

Test Plan:
- Reset asserted mid-cycle, then released -> req_ready=1, rsp_valid=0, busy=0, rsp_rdata=0 immediately on assertion, without waiting for a clock edge.
- LATENCY=2: write 0xDEADBEEF to 0x10, wstrb=4'hF, accepted at edge 0 -> busy=1, rsp_valid high after edge 2, rsp_err=0; read 0x10 -> rsp_rdata=0xDEADBEEF after edge 2 of that read.
- Then write 0x00AA0000 to 0x10 with wstrb=4'b0100 -> read 0x10 returns 0xDEAABEEF; write with wstrb=0 leaves 0xDEAABEEF.
- Read 0x13 and write 0x1000 (DEPTH_WORDS=1024) -> rsp_valid in the cycle after acceptance, rsp_err=1, rsp_rdata=0, array unchanged.
- Read with rsp_ready held low 5 cycles -> rsp_valid, rsp_rdata, rsp_err stable, req_ready=0, a concurrent req_valid is ignored; rsp_ready=1 -> IDLE next cycle.
- LATENCY=3: write 0x55 to 0x20, assert rst during WAIT -> outputs at reset values; read 0x20 returns the prior value. Repeat with LATENCY=0 -> response in the cycle after acceptance.
